// File: rtl/aes_pkg.sv
// ============================================================================
//  aes_pkg
//  Shared AES constants: S-box, Rcon, round count and key-schedule FSM states.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int AES_ROUNDS = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ks_state_e;

    // Entry 0 occupies the top byte, so entry b lives at bit offset 8*(255-b).
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sub_word.sv
// ============================================================================
//  aes_sub_word
//  Combinational SubWord: four parallel S-box lookups on a 32-bit word.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign o_word[8*gi +: 8] = sbox(i_word[8*gi +: 8]);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/aes_key_expand_seq.sv
// ============================================================================
//  aes_key_expand_seq
//  Iterative AES-128 key schedule, one round key per handshake.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_ROUNDS
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [127:0] i_key,
    input  logic         i_start,
    output logic         o_busy,
    output logic [127:0] o_round_key,
    output logic [3:0]   o_round_idx,
    output logic         o_key_valid,
    input  logic         i_ready,
    output logic         o_done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ks_state_e    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;

    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next_key;
    logic [3:0]   w_next_idx;

    assign w_next_idx = idx_q + 4'd1;
    assign w_rot      = {key_q[23:0], key_q[31:24]};

    aes_sub_word u_sub_word (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    // Each new word chains off the one just produced, not the old key.
    assign w_t        = w_sub ^ {rcon(w_next_idx), 24'h000000};
    assign w_n0       = key_q[127:96] ^ w_t;
    assign w_n1       = key_q[95:64]  ^ w_n0;
    assign w_n2       = key_q[63:32]  ^ w_n1;
    assign w_n3       = key_q[31:0]   ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    key_d   = i_key;
                    idx_d   = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (i_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = w_next_key;
                        idx_d = w_next_idx;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_busy      = (state_q == ST_EMIT);
    assign o_key_valid = (state_q == ST_EMIT);
    assign o_round_key = key_q;
    assign o_round_idx = idx_q;
    assign o_done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand_seq.sv
// ============================================================================
//  tb_aes_key_expand_seq
//  Randomised bench against a word-wise FIPS-197 key-expansion model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes_key_expand_seq;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ARK_STATE = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk;
    logic         rst;
    logic [127:0] key;
    logic         start;
    logic         busy;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         ready;
    logic         done;

    int n_checks;
    int n_errors;

    logic [7:0]   tb_sbox  [0:255];
    logic [127:0] ref_keys [0:10];
    logic [127:0] got_keys [0:10];

    aes_key_expand_seq #(.NUM_ROUNDS(10)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_key       (key),
        .i_start     (start),
        .o_busy      (busy),
        .o_round_key (round_key),
        .o_round_idx (round_idx),
        .o_key_valid (key_valid),
        .i_ready     (ready),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box built from the GF(2^8) inverse plus the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h01;
            if (b == 0) inv = 8'h00;
            else for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(b));
            tb_sbox[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                       ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]], tb_sbox[t[31:24]]}
                    ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One full schedule. Ends at the negedge of the done cycle when chain=1.
    task automatic run_sched(input logic [127:0] k, input int stall_at, input int stall_len,
                             input int poke_at, input bit skip_wait, input bit chain);
        int  e;
        int  stalled;
        int  cyc;
        bit  poked;
        expand_model(k);
        if (!skip_wait) @(negedge clk);
        key   = k;
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key   = {$urandom, $urandom, $urandom, $urandom};
        e = 0; stalled = 0; cyc = 1; poked = 1'b0;
        while (e <= 10 && cyc < 64) begin
            chk("valid", key_valid, 1);
            chk("busy", busy, 1);
            chk("idx", round_idx, e);
            chk("key", round_key, ref_keys[e]);
            if (e == poke_at && !poked) begin
                start = 1'b1;
                key   = ~k;
                poked = 1'b1;
            end
            if (e == stall_at && stalled < stall_len) begin
                ready = 1'b0;
                stalled++;
            end else begin
                ready = 1'b1;
                got_keys[e] = round_key;
                e++;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        chk("sched_complete", (e == 11), 1);
        chk("done_cycle", cyc, 12 + stall_len);
        chk("done_pulse", done, 1);
        chk("done_valid", key_valid, 0);
        chk("done_busy", busy, 0);
        if (!chain) begin
            @(negedge clk);
            chk("done_clear", done, 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        key   = '0;
        build_sbox();

        repeat (3) @(negedge clk);
        chk("rst_valid", key_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_key", round_key, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_valid", key_valid, 0);

        run_sched(FIPS_KEY, -1, 0, -1, 1'b0, 1'b0);
        chk("fips0", got_keys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk("fips1", got_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips2", got_keys[2], 128'hf2c295f27a96b9435935807a7359f67f);
        chk("fips3", got_keys[3], 128'h3d80477d4716fe3e1e237e446d7a883b);
        chk("fips10", got_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("ark_idx0", got_keys[0] ^ ARK_STATE, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

        run_sched('0, -1, 0, -1, 1'b0, 1'b0);
        chk("zero1", got_keys[1], 128'h62636363626363636263636362636363);
        chk("zero10", got_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        run_sched(FIPS_KEY, 4, 3, -1, 1'b0, 1'b0);
        run_sched(FIPS_KEY, -1, 0, 5, 1'b0, 1'b0);
        chk("poke_fips10", got_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Mid-schedule reset at idx 6
        @(negedge clk);
        key = FIPS_KEY; start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 30 && round_idx != 4'd6; c++) @(negedge clk);
        chk("pre_rst_idx", round_idx, 6);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_idx", round_idx, 0);
        chk("mid_rst_key", round_key, 0);
        rst = 1'b0;
        run_sched(FIPS_KEY, -1, 0, -1, 1'b0, 1'b0);

        // Back-to-back: restart in the done cycle
        run_sched({$urandom, $urandom, $urandom, $urandom}, 2, 1, -1, 1'b0, 1'b1);
        run_sched({$urandom, $urandom, $urandom, $urandom}, -1, 0, 3, 1'b1, 1'b0);

        for (int n = 0; n < 6; n++) begin
            run_sched({$urandom, $urandom, $urandom, $urandom},
                      int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 10)), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_key_expand_seq.md
# aes_key_expand_seq

Iterative AES-128 key-schedule generator. It produces the eleven 128-bit round keys (round 0..10) one at a time, in order, over a valid/ready handshake. It sits directly upstream of `add_round_key`, whose `i_key` input is driven from `o_round_key`. Each round key is computed from the previous one in a single cycle, so no round-key storage array is needed.

## Interface
Parameters:
- `NUM_ROUNDS`, default 10; index of the last round key generated. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_key`  in  128  cipher key; sampled only on start acceptance.
- `i_start`  in  1  start request; accepted only when `o_busy`=0.
- `o_busy`  out  1  1 from the cycle after acceptance through the final handshake.
- `o_round_key`  out  128  current round key, byte 0 in bits [127:120].
- `o_round_idx`  out  4  index of `o_round_key`, 0..10.
- `o_key_valid`  out  1  `o_round_key`/`o_round_idx` are valid.
- `i_ready`  in  1  consumer accepts the current key when `o_key_valid`&&`i_ready`.
- `o_done`  out  1  one-cycle pulse, asserted in the cycle after the round-10 handshake.

## Operation
- FSM states:
  - IDLE: `o_busy`=0, `o_key_valid`=0. On `i_start`: latch `i_key` into the key register, set idx=0, go to EMIT.
  - EMIT: `o_key_valid`=1.
    - On handshake with idx<10: key ← next(key, idx+1), idx ← idx+1, stay in EMIT.
    - On handshake with idx=10: go to IDLE and pulse `o_done`.
    - Without a handshake: key, idx and valid hold stable. This is mandatory backpressure behaviour.
- next(w, r), with words w0..w3 taken MSB-first:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- RotWord rotates bytes left by one: {b1,b2,b3,b0}.
- All XORs are 128-bit or 32-bit exact; there are no carries.
- `i_start` is ignored while `o_busy`=1. A new key cannot be loaded mid-schedule.
- `i_start` is accepted in the same cycle `o_done` is high, because the FSM is already in IDLE.
- `i_key` changes after acceptance have no effect.
- Reset (any state, including mid-schedule) sets:
  - `o_busy`=0, `o_key_valid`=0, `o_done`=0, `o_round_idx`=0, `o_round_key`=0, state IDLE.

## Timing
- Start accepted at edge N:
  - round 0 is valid from the cycle after edge N.
  - with `i_ready` held at 1, round k is valid in cycle N+1+k.
  - round 10 is valid in cycle N+11.
  - `o_done` is high in cycle N+12.
- Minimum schedule: 11 valid cycles plus 1 done cycle. Back-to-back restart is allowed with `i_start` in the `o_done` cycle.
- All outputs are registered; there is no combinational path from `i_ready` or `i_start` to any output.
- The critical path is 4 S-box lookups in parallel plus 4 XOR levels. It must close in one cycle; pipelining is not permitted.

## Structure
- Shared package `aes_pkg`:
  - the Rcon table
  - the S-box table as a 256×8 constant, shared with the sub_bytes stage
  - the FSM state enum
  - `AES_ROUNDS`=10
- Sub-module `aes_sub_word`: combinational, 32-bit in and out, four S-box instances. Instantiated once here and reusable by other stages.
- Top level contains only the FSM, the idx counter, the key register, and the next-key XOR network.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `i_ready`=1:
  - idx0 = 2b7e151628aed2a6abf7158809cf4f3c
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx2 = f2c295f27a96b9435935807a7359f67f
  - idx3 = 3d80477d4716fe3e1e237e446d7a883b
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - `o_done` in cycle N+12.
- All-zero key:
  - idx1 = 62636363626363636263636362636363
  - idx10 = b4ef5bcb3e92e21123e951cf6f8f188e
- Backpressure with FIPS key: drop `i_ready` for 3 cycles at idx 4 → key/idx/valid remain stable for those 3 cycles; sequence values unchanged; `o_done` is delayed by exactly 3 cycles.
- `i_start` pulsed with a different key at idx 5 → ignored; sequence completes with the original FIPS values.
- `i_rst` asserted at idx 6 → all outputs are 0 the next cycle. A restart then produces the full, correct sequence from idx 0.
- Integration: drive `add_round_key` with state 3243f6a8885a308d313198a2e0370734 and idx0 → output 193de3bea0f4e22b9ac68d2ae9f84808.
